// File: rtl/lsu_pkg.sv
// Shared types for the MEMPREP load/store unit.
// Width encodings, FSM states and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    DW_BYTE = 2'b00,
    DW_HALF = 2'b01,
    DW_WORD = 2'b10
  } data_width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  function automatic logic is_aligned(
    input logic [1:0] width,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      width == DW_BYTE: ok = 1'b1;
      width == DW_HALF: ok = ~off[0];
      width == DW_WORD: ok = (off == 2'b00);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering / byte enables and load lane extract / extend.
// Purely combinational; the FSM lives in the top.
import lsu_pkg::*;

module lsu_align (
  input  logic [1:0]  st_width,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane,
  input  logic [1:0]  ld_width,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    st_be   = 4'b1111;
    st_lane = st_data;
    unique case (1'b1)
      st_width == DW_BYTE: begin
        st_be   = 4'b0001 << st_off;
        st_lane = {4{st_data[7:0]}};
      end
      st_width == DW_HALF: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_lane = {2{st_data[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_lane = st_data;
      end
    endcase
  end

  always_comb begin
    ld_b    = 8'(ld_word >> {ld_off, 3'b000});
    ld_h    = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    unique case (1'b1)
      ld_width == DW_BYTE:
        ld_data = {{24{ld_sext & ld_b[7]}}, ld_b};
      ld_width == DW_HALF:
        ld_data = {{16{ld_sext & ld_h[15]}}, ld_h};
      default:
        ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// MEMPREP data-memory access: one in-order valid/ready request
// per load/store, stalls upstream until the access completes.
import lsu_pkg::*;

module lsu_mem_access #(
  parameter int RSP_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        mem_op,
  input  logic        lsu_we,
  input  logic        lsu_sign_extend,
  input  logic [1:0]  data_width,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(RSP_TIMEOUT - 1);

  lsu_state_e state_q, state_d;

  logic [29:0]     addr_q;
  logic [1:0]      off_q;
  logic [1:0]      width_q;
  logic            we_q;
  logic            sext_q;
  logic            mis_q;
  logic            err_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     ld_q;
  logic [TO_W-1:0] cnt_q;

  logic        start;
  logic        ok;
  logic        to_hit;
  logic        in_req;
  logic [3:0]  st_be;
  logic [31:0] st_lane;
  logic [31:0] ld_ext;

  assign start  = op_valid & mem_op;
  assign ok     = is_aligned(data_width, addr[1:0]);
  assign to_hit = (RSP_TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign in_req = (state_q == S_REQ);

  lsu_align u_align (
    .st_width (data_width),
    .st_off   (addr[1:0]),
    .st_data  (wdata),
    .st_be    (st_be),
    .st_lane  (st_lane),
    .ld_width (width_q),
    .ld_off   (off_q),
    .ld_sext  (sext_q),
    .ld_word  (bus_rdata),
    .ld_data  (ld_ext)
  );

  // Bus fields are only driven while the request is up.
  assign bus_req_valid = in_req;
  assign bus_addr  = in_req ? {addr_q, 2'b00} : '0;
  assign bus_we    = in_req & we_q;
  assign bus_be    = in_req ? be_q : '0;
  assign bus_wdata = in_req ? wdata_q : '0;
  assign load_data = ld_q;

  always_comb begin
    state_d    = state_q;
    lsu_stall  = 1'b0;
    lsu_done   = 1'b0;
    misaligned = 1'b0;
    bus_error  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lsu_stall = start;
        if (start) state_d = ok ? S_REQ : S_DONE;
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (bus_req_ready)
          state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        if (bus_rsp_valid || to_hit) state_d = S_DONE;
      end
      S_DONE: begin
        lsu_done   = 1'b1;
        misaligned = mis_q;
        bus_error  = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr[31:2];
            off_q   <= addr[1:0];
            width_q <= data_width;
            we_q    <= lsu_we;
            sext_q  <= lsu_sign_extend;
            be_q    <= st_be;
            wdata_q <= st_lane;
            mis_q   <= ~ok;
            err_q   <= 1'b0;
          end
        end
        S_REQ: cnt_q <= '0;
        S_WAIT: begin
          // A real response wins over a same-cycle timeout.
          if (bus_rsp_valid) begin
            ld_q <= ld_ext;
          end else if (to_hit) begin
            ld_q  <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a transaction-level model
// and a per-cycle compare process.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, mem_op, lsu_we, lsu_sign_extend;
  logic [1:0]  data_width;
  logic [31:0] addr, wdata;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        lsu_stall, lsu_done;
  logic [31:0] load_data;
  logic        misaligned, bus_error;

  always #5 clk = ~clk;

  lsu_mem_access #(.RSP_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .mem_op(mem_op),
    .lsu_we(lsu_we), .lsu_sign_extend(lsu_sign_extend),
    .data_width(data_width), .addr(addr), .wdata(wdata),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected transaction, set by the driver, read by the compare.
  logic        inflight = 1'b0;
  int          exp_done = 0;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;
  logic        exp_we, exp_mis, exp_err, exp_load;
  logic [31:0] model_ld = '0;
  int          done_cnt = 0;
  int          done_at = 0;
  logic [3:0]  seen_be = '0;
  logic [31:0] seen_wdata = '0;

  function automatic logic m_aligned(input logic [1:0] w,
                                     input logic [31:0] a);
    return (w == 2'd0) || (w == 2'd1 && a % 2 == 0) ||
           (w == 2'd2 && a % 4 == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] w,
                                      input logic [1:0] off);
    if (w == 2'd0) return 4'(1 << off);
    if (w == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] w,
                                          input logic [31:0] d);
    if (w == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (w == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w,
                                         input logic [1:0] off,
                                         input logic sx,
                                         input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * off);
    if (w == 2'd0) begin
      s = s & 32'hFF;
      if (sx && s[7]) s = s | 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      s = s & 32'hFFFF;
      if (sx && s[15]) s = s | 32'hFFFF_0000;
    end else begin
      s = rd;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl", {25'h0, bus_req_valid, bus_we, lsu_stall,
          lsu_done, misaligned, bus_error, 1'b0}, 32'h0);
      chk("rst_be", {28'h0, bus_be}, 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_load", load_data, 32'h0);
      model_ld = '0;
    end else if (inflight) begin
      chk("done_time", {31'h0, lsu_done},
          {31'h0, cyc == exp_done});
      chk("stall", {31'h0, lsu_stall},
          {31'h0, cyc != exp_done});
      chk("req_on_mis", {31'h0, bus_req_valid & exp_mis}, 32'h0);
      if (bus_req_valid) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
        chk("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
        chk("bus_wdata", bus_wdata, exp_wdata);
        seen_be = bus_be;
        seen_wdata = bus_wdata;
      end
      if (lsu_done) begin
        chk("misaligned", {31'h0, misaligned}, {31'h0, exp_mis});
        chk("bus_error", {31'h0, bus_error}, {31'h0, exp_err});
        if (exp_load && !exp_mis)
          model_ld = exp_err ? 32'h0 : exp_ld;
        chk("load_data", load_data, model_ld);
        done_at = cyc;
        done_cnt++;
      end else begin
        chk("load_hold", load_data, model_ld);
      end
    end else begin
      chk("idle_ctl", {27'h0, bus_req_valid, lsu_stall, lsu_done,
          misaligned, bus_error}, 32'h0);
      chk("load_hold", load_data, model_ld);
    end
  end

  task automatic run(input logic we, input logic sx,
                     input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd,
                     input int rdly, input int pdly,
                     input logic norsp, output int lat);
    logic ok;
    int s;
    int dc0;
    ok = m_aligned(w, a);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = 1'b1;
    lsu_we = we; lsu_sign_extend = sx;
    data_width = w; addr = a; wdata = d;
    s = cyc;
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_we    = we;
    exp_be    = m_be(w, a[1:0]);
    exp_wdata = m_wdata(w, d);
    exp_ld    = m_load(w, a[1:0], sx, rd);
    exp_mis   = !ok;
    exp_load  = !we;
    exp_err   = ok && !we && norsp;
    if (!ok)       exp_done = s + 1;
    else if (we)   exp_done = s + 2 + rdly;
    else if (norsp) exp_done = s + 6 + rdly;
    else           exp_done = s + 3 + rdly + pdly;
    dc0 = done_cnt;
    inflight = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the access must use the latched copy.
    op_valid = 1'b0;
    addr = 32'hFFFF_FFFF; wdata = ~d; lsu_we = ~we;
    data_width = 2'd3; lsu_sign_extend = ~sx;
    if (ok) begin
      bus_req_ready = 1'b0;
      repeat (rdly) begin @(posedge clk); #1; end
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      if (!we && !norsp) begin
        repeat (pdly) begin @(posedge clk); #1; end
        bus_rsp_valid = 1'b1;
        bus_rdata = rd;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        bus_rdata = ~rd;
      end
    end
    for (int i = 0; i < 20 && done_cnt == dc0; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(done_cnt - dc0), 32'd1);
    inflight = 1'b0;
    lat = done_at - s;
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    op_valid = 1'b0; mem_op = 1'b0; lsu_we = 1'b0;
    lsu_sign_extend = 1'b0; data_width = 2'd0;
    addr = '0; wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(1, 0, 2'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_be", {28'h0, seen_be}, 32'hF);
    chk("sw_wdata", seen_wdata, 32'hDEAD_BEEF);

    run(0, 1, 2'd0, 32'h103, 0, 32'h80FF_FF7F, 0, 0, 0, lat);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_val", load_data, 32'hFFFF_FF80);

    run(0, 0, 2'd0, 32'h103, 0, 32'h80FF_FF7F, 0, 2, 0, lat);
    chk("lbu_val", load_data, 32'h0000_0080);

    run(1, 0, 2'd1, 32'h202, 32'h1234_ABCD, 0, 3, 0, 0, lat);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_be", {28'h0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);

    run(0, 0, 2'd2, 32'h101, 0, 0, 0, 0, 0, lat);
    chk("mis_lat", 32'(lat), 32'd1);

    run(0, 1, 2'd1, 32'h106, 0, 32'h8001_7FFF, 1, 1, 0, lat);
    chk("lh_val", load_data, 32'hFFFF_8001);

    run(1, 0, 2'd0, 32'h7, 32'h0000_00A5, 0, 0, 0, 0, lat);
    chk("sb_be", {28'h0, seen_be}, 32'h8);
    chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);

    run(1, 0, 2'd3, 32'h10, 32'h1, 0, 0, 0, 0, lat);
    run(0, 0, 2'd1, 32'h200, 0, 32'h1234_F00D, 0, 0, 0, lat);
    chk("lhu_val", load_data, 32'h0000_F00D);

    run(0, 0, 2'd2, 32'h400, 0, 0, 1, 0, 1, lat);
    chk("to_lat", 32'(lat), 32'd7);
    chk("to_val", load_data, 32'h0);

    run(1, 0, 2'd1, 32'h203, 32'h5, 0, 0, 0, 0, lat);

    // Abandon a load in WAIT with an asynchronous reset.
    run(0, 0, 2'd2, 32'h300, 0, 32'h1111_2222, 0, 0, 0, lat);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = 1'b1; lsu_we = 1'b0;
    data_width = 2'd2; addr = 32'h304;
    exp_mis = 1'b0; exp_we = 1'b0; exp_be = 4'hF;
    exp_addr = 32'h304; exp_wdata = m_wdata(2'd2, wdata);
    exp_load = 1'b1; exp_err = 1'b0;
    exp_done = cyc + 100;
    inflight = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    inflight = 1'b0;
    #1;
    chk("async_rst", {26'h0, bus_req_valid, lsu_stall, lsu_done,
        misaligned, bus_error, bus_we}, 32'h0);
    chk("async_rst_ld", load_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);

    run(0, 0, 2'd2, 32'h300, 0, 32'hCAFE_F00D, 0, 1, 0, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_val", load_data, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
